xor_train_sequencer: RTL and testbench

Hardware training driver for the XOR network core, the initiator side of the core's training interface. It replaces bench-driven stimulus with an on-chip sequencer. It holds the four XOR patterns in Q8.8 and presents them in a fixed order, one sample per core handshake. It accumulates per-epoch absolute error from the core's output and stops on convergence, on the epoch limit, or on a core timeout.

---
 rtl/xor_nn_pkg.sv | 27 ++
 rtl/abs_err_sat.sv | 19 +
 rtl/xor_train_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_xor_train_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_nn_pkg.sv
// Shared constants for the XOR network: Q8.8 values, training pattern table,
// sequencer state encoding and saturation limits.
package xor_nn_pkg;

  localparam int unsigned PkgDataW = 16;

  localparam logic [PkgDataW-1:0] Q_ONE  = 16'd256;
  localparam logic [PkgDataW-1:0] Q_ZERO = 16'd0;

  // Entries listed from index 3 down to index 0
  localparam logic [3:0][PkgDataW-1:0] PAT_X1  = {Q_ONE,  Q_ONE,  Q_ZERO, Q_ZERO};
  localparam logic [3:0][PkgDataW-1:0] PAT_X2  = {Q_ONE,  Q_ZERO, Q_ONE,  Q_ZERO};
  localparam logic [3:0][PkgDataW-1:0] PAT_TGT = {Q_ZERO, Q_ONE,  Q_ONE,  Q_ZERO};

  localparam logic [PkgDataW-1:0] ERR_MAX = 16'h7FFF;
  localparam logic [PkgDataW+1:0] SUM_MAX = 18'h1FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StAccum,
    StEpochEnd,
    StDone
  } state_e;

endpackage

// File: rtl/abs_err_sat.sv
// Combinational saturating absolute difference |a - b| of two signed Q8.8 values.
module abs_err_sat
  import xor_nn_pkg::*;
(
  input  logic [PkgDataW-1:0] a_i,
  input  logic [PkgDataW-1:0] b_i,
  output logic [PkgDataW-1:0] err_o
);

  logic signed [PkgDataW:0] diff;
  logic        [PkgDataW:0] mag;

  always_comb begin
    diff  = $signed({a_i[PkgDataW-1], a_i}) - $signed({b_i[PkgDataW-1], b_i});
    mag   = diff[PkgDataW] ? $unsigned(-diff) : $unsigned(diff);
    err_o = (mag > {1'b0, ERR_MAX}) ? ERR_MAX : mag[PkgDataW-1:0];
  end

endmodule

// File: rtl/xor_train_sequencer.sv
// On-chip training driver: issues the four XOR samples per epoch to the core,
// accumulates absolute error and stops on convergence, epoch limit or timeout.
module xor_train_sequencer
  import xor_nn_pkg::*;
#(
  parameter int unsigned        DATA_W         = 16,
  parameter logic [DATA_W-1:0]  ERR_THRESH     = 16'd64,
  parameter int unsigned        TIMEOUT_CYCLES = 4096,
  parameter int unsigned        CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic [CNT_W-1:0]  max_epochs_in,
  output logic              nn_start,
  output logic [DATA_W-1:0] nn_x1,
  output logic [DATA_W-1:0] nn_x2,
  output logic [DATA_W-1:0] nn_target,
  input  logic              nn_sample_done,
  input  logic [DATA_W-1:0] nn_y,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              timeout,
  output logic [CNT_W-1:0]  epoch_count,
  output logic [DATA_W+1:0] last_epoch_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_W+2:0] SumMaxExt = (DATA_W + 3)'(SUM_MAX);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W+1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  epoch_q, epoch_d;
  logic [DATA_W+1:0] last_err_q, last_err_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d, tgt_q, tgt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              conv_q, conv_d, tmo_q, tmo_d;

  logic [DATA_W-1:0] err;
  logic [DATA_W+2:0] sum_ext;
  logic [CNT_W-1:0]  epoch_inc;
  logic              issue;
  logic [1:0]        issue_idx;

  abs_err_sat u_abs_err_sat (
    .a_i   (y_q),
    .b_i   (tgt_q),
    .err_o (err)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    y_d        = y_q;
    sum_d      = sum_q;
    limit_d    = limit_q;
    epoch_d    = epoch_q;
    last_err_d = last_err_q;
    start_d    = 1'b0;
    x1_d       = x1_q;
    x2_d       = x2_q;
    tgt_d      = tgt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    conv_d     = conv_q;
    tmo_d      = tmo_q;
    issue      = 1'b0;
    issue_idx  = 2'd0;
    sum_ext    = {1'b0, sum_q} + {3'b000, err};
    epoch_inc  = epoch_q + 1'b1;

    if (abort) begin
      // Counters and sample registers are deliberately left untouched for debug
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (go) begin
            limit_d = (max_epochs_in == '0) ? CNT_W'(1) : max_epochs_in;
            epoch_d = '0;
            sum_d   = '0;
            idx_d   = 2'd0;
            done_d  = 1'b0;
            conv_d  = 1'b0;
            tmo_d   = 1'b0;
            busy_d  = 1'b1;
            issue   = 1'b1;
          end
        end
        StIssue: begin
          wait_d  = '0;
          state_d = StWait;
        end
        StWait: begin
          if (nn_sample_done) begin
            y_d     = nn_y;
            state_d = StAccum;
          end else if (wait_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        StAccum: begin
          sum_d = (sum_ext > SumMaxExt) ? SumMaxExt[DATA_W+1:0] : sum_ext[DATA_W+1:0];
          if (idx_q == 2'd3) begin
            state_d = StEpochEnd;
          end else begin
            idx_d     = idx_q + 2'd1;
            issue     = 1'b1;
            issue_idx = idx_q + 2'd1;
          end
        end
        StEpochEnd: begin
          epoch_d    = epoch_inc;
          last_err_d = sum_q;
          if (sum_q <= {2'b00, ERR_THRESH}) begin
            conv_d  = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end else if (epoch_inc == limit_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            sum_d = '0;
            idx_d = 2'd0;
            issue = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      // Sample registers load on entry to ISSUE so they are valid with nn_start
      if (issue) begin
        state_d = StIssue;
        start_d = 1'b1;
        x1_d    = PAT_X1[issue_idx];
        x2_d    = PAT_X2[issue_idx];
        tgt_d   = PAT_TGT[issue_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      wait_q     <= '0;
      y_q        <= '0;
      sum_q      <= '0;
      limit_q    <= '0;
      epoch_q    <= '0;
      last_err_q <= '0;
      start_q    <= 1'b0;
      x1_q       <= '0;
      x2_q       <= '0;
      tgt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      y_q        <= y_d;
      sum_q      <= sum_d;
      limit_q    <= limit_d;
      epoch_q    <= epoch_d;
      last_err_q <= last_err_d;
      start_q    <= start_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      tgt_q      <= tgt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conv_q     <= conv_d;
      tmo_q      <= tmo_d;
    end
  end

  assign nn_start       = start_q;
  assign nn_x1          = x1_q;
  assign nn_x2          = x2_q;
  assign nn_target      = tgt_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign converged      = conv_q;
  assign timeout        = tmo_q;
  assign epoch_count    = epoch_q;
  assign last_epoch_err = last_err_q;

endmodule

// File: tb/tb_xor_train_sequencer.sv
// Scoreboard bench for xor_train_sequencer with a behavioural core model.
module tb_xor_train_sequencer;

  localparam int unsigned TimeoutCycles = 4096;

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] x2;
    logic [15:0] t;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst, go, abort;
  logic [15:0] max_epochs_in;
  logic        nn_start, nn_sample_done;
  logic [15:0] nn_x1, nn_x2, nn_target, nn_y;
  logic        busy, done, converged, timeout;
  logic [15:0] epoch_count;
  logic [17:0] last_epoch_err;

  // Core model controls
  logic        resp_en   = 1'b1;
  int          resp_dly  = 1;
  logic        y_echo    = 1'b1;
  logic [15:0] y_fixed   = '0;
  logic        model_done = 1'b0;
  logic [15:0] model_y    = '0;
  int          model_cnt  = 0;
  logic        spur_done  = 1'b0;
  logic [15:0] spur_y     = 16'h4000;

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   start_cnt = 0;
  int   base;
  smp_t exp_q[$];

  assign nn_sample_done = model_done | spur_done;
  assign nn_y           = spur_done ? spur_y : model_y;

  always #5 clk = ~clk;

  xor_train_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .go             (go),
    .abort          (abort),
    .max_epochs_in  (max_epochs_in),
    .nn_start       (nn_start),
    .nn_x1          (nn_x1),
    .nn_x2          (nn_x2),
    .nn_target      (nn_target),
    .nn_sample_done (nn_sample_done),
    .nn_y           (nn_y),
    .busy           (busy),
    .done           (done),
    .converged      (converged),
    .timeout        (timeout),
    .epoch_count    (epoch_count),
    .last_epoch_err (last_epoch_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic smp_t pattern(input int i);
    smp_t s;
    case (i)
      0: s = '{x1: 16'd0,   x2: 16'd0,   t: 16'd0};
      1: s = '{x1: 16'd0,   x2: 16'd256, t: 16'd256};
      2: s = '{x1: 16'd256, x2: 16'd0,   t: 16'd256};
      default: s = '{x1: 16'd256, x2: 16'd256, t: 16'd0};
    endcase
    return s;
  endfunction

  task automatic push_samples(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pattern(i % 4));
  endtask

  // Core model: respond resp_dly cycles after each nn_start
  always @(negedge clk) begin
    model_done = 1'b0;
    if (rst) begin
      model_cnt = 0;
    end else begin
      if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) begin
          model_done = 1'b1;
          model_y    = y_echo ? nn_target : y_fixed;
        end
      end
      if (nn_start && resp_en) model_cnt = resp_dly;
    end
  end

  // Scoreboard: every nn_start must match the next expected sample
  always @(negedge clk) begin
    if (!rst && nn_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        check("start_extra", 64'd1, 64'd0);
      end else begin
        smp_t e;
        e = exp_q.pop_front();
        check("sample", {16'd0, nn_x1, nn_x2, nn_target}, {16'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] limit);
    base          = start_cnt;
    go            = 1'b1;
    max_epochs_in = limit;
    step();
    go            = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      step();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; max_epochs_in = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_flags", 64'({done, converged, timeout, nn_start}), 64'd0);
    check("rst_x",     {16'd0, nn_x1, nn_x2, nn_target}, 64'd0);
    check("rst_cnt",   64'({epoch_count, last_epoch_err}), 64'd0);

    // 1: perfect core, converges after one epoch
    resp_dly = 2; y_echo = 1'b1;
    push_samples(4);
    start_run(16'd12);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(200);
    check("t1_conv",   64'({converged, timeout, busy}), 64'b100);
    check("t1_epoch",  64'(epoch_count), 64'd1);
    check("t1_err",    64'(last_epoch_err), 64'd0);
    check("t1_starts", 64'(start_cnt - base), 64'd4);
    check("t1_q",      64'(exp_q.size()), 64'd0);

    // 2: constant y=128 never converges; epoch limit stops it
    resp_dly = 1; y_echo = 1'b0; y_fixed = 16'd128;
    push_samples(12);
    start_run(16'd3);
    wait_done(400);
    check("t2_conv",   64'({converged, timeout}), 64'b00);
    check("t2_epoch",  64'(epoch_count), 64'd3);
    check("t2_err",    64'(last_epoch_err), 64'd512);
    check("t2_starts", 64'(start_cnt - base), 64'd12);

    // 3: core never responds
    resp_en = 1'b0;
    push_samples(1);
    start_run(16'd5);
    wait_done(TimeoutCycles + 100);
    check("t3_flags",  64'({timeout, converged, busy}), 64'b100);
    check("t3_epoch",  64'(epoch_count), 64'd0);
    check("t3_starts", 64'(start_cnt - base), 64'd1);
    resp_en = 1'b1;

    // 4: most negative output saturates each sample error
    y_fixed = 16'h8000;
    push_samples(4);
    start_run(16'd1);
    wait_done(200);
    check("t4_err",  64'(last_epoch_err), 64'(4 * 32767));
    check("t4_conv", 64'({converged, epoch_count}), 64'({1'b0, 16'd1}));

    // 5: abort in WAIT of epoch 2, then restart
    resp_dly = 3; y_fixed = 16'd128;
    push_samples(6);
    start_run(16'd5);
    for (int n = 0; n < 200 && (start_cnt - base) < 6; n++) step();
    check("t5_reach", 64'(start_cnt - base), 64'd6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort", 64'({busy, done, nn_start}), 64'b000);
    check("t5_hold",  64'(epoch_count), 64'd1);
    repeat (10) step();
    check("t5_quiet", 64'(start_cnt - base), 64'd6);
    push_samples(4);
    start_run(16'd1);
    check("t5_restart_epoch", 64'(epoch_count), 64'd0);
    wait_done(200);
    check("t5_err", 64'(last_epoch_err), 64'd512);

    // 6: spurious done while DONE, spurious done and go during ISSUE, limit 0
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    check("t6_done_hold", 64'({done, epoch_count, last_epoch_err}),
          64'({1'b1, 16'd1, 18'd512}));
    resp_dly = 4;
    push_samples(4);
    start_run(16'd0);
    spur_done     = 1'b1;
    go            = 1'b1;
    max_epochs_in = 16'd7;
    step();
    spur_done = 1'b0;
    go        = 1'b0;
    wait_done(200);
    check("t6_epoch",  64'(epoch_count), 64'd1);
    check("t6_err",    64'(last_epoch_err), 64'd512);
    check("t6_starts", 64'(start_cnt - base), 64'd4);
    check("t6_conv",   64'(converged), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
